ifu_prefetch: RTL
=================

# ifu_prefetch

Instruction fetch unit with a small prefetch FIFO. It sits between the instruction ROM and the IF/ID pipeline register, replacing the direct wiring of pc_gen to the ROM. It issues sequential fetches over a request/grant ROM port and buffers returned instructions with their PCs. On a taken branch it flushes the buffer, discards in-flight responses and restarts at the target.

## Interface
Parameters:
- DEPTH, 4: prefetch FIFO entries; power of two, minimum 2.
- RESET_PC, 0: first fetch address after reset.
- PC_STEP, 4: address increment per sequential fetch.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- redirect  in  1  taken branch/jump (branch_ex & alu_zero); single-cycle pulse.
- redirect_pc  in  `BUS_WIDTH  target address; valid when redirect=1.
- rom_req  out  1  fetch request.
- rom_addr  out  `BUS_WIDTH  fetch address.
- rom_gnt  in  1  request accepted this cycle (req & gnt = issue).
- rom_rvalid  in  1  response valid; responses arrive in issue order, at least 1 cycle after their grant.
- rom_rdata  in  `DATA_WIDTH  response instruction word.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  IF/ID accepts the head (0 = hold/stall).
- inst_data  out  `DATA_WIDTH  head instruction.
- inst_pc  out  `BUS_WIDTH  PC of head instruction.

## Operation
- State registers:
  - fetch_pc: next address to issue.
  - out_cnt: granted requests not yet returned, 0..DEPTH.
  - drop_cnt: responses still to be discarded, 0..DEPTH.
  - FIFO: data+PC per entry, read/write pointers and count.
- Issue:
  - rom_req=1 when no redirect this cycle and fifo_count + out_cnt < DEPTH; rom_addr=fetch_pc.
  - On req&gnt: fetch_pc += PC_STEP (modulo 2^`BUS_WIDTH, wraps silently) and out_cnt increments.
  - Request may be withdrawn before grant; no commitment exists until gnt.
- Response:
  - On rom_rvalid: out_cnt decrements.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {rom_rdata, pc} is pushed. pc comes from a parallel PC tag queue of DEPTH entries, written at grant.
  - The credit rule guarantees the FIFO never overflows. rvalid arriving with out_cnt==0 is a protocol error: assert in simulation, ignore in RTL.
- Pop: inst_valid & inst_ready removes the head.
- Redirect (highest priority):
  - FIFO and PC tag queue are emptied.
  - drop_cnt <= out_cnt − (rom_rvalid ? 1 : 0) + drop_cnt adjustment (net: every request granted before the redirect is discarded).
  - fetch_pc <= redirect_pc.
  - rom_req=0 in the redirect cycle.
  - A simultaneous pop or push that cycle is ignored.
- Simultaneous push and pop on a non-empty FIFO: count unchanged.
- Reset mid-operation: all state is cleared immediately. Responses to requests granted before reset are the system's responsibility; the ROM is reset by the same rst_n.

## Timing
- Reset values: rom_req=0, rom_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0; fetch_pc=RESET_PC, all counters 0.
- First cycle after rst_n release: rom_req=1, rom_addr=RESET_PC.
- Latency: grant at cycle N, rvalid at N+k, inst_valid at N+k+1 (FIFO output registered, no bypass).
- Throughput: with a 1-cycle ROM and inst_ready=1, one instruction per cycle for DEPTH≥3.
- Redirect at cycle R: rom_req=1 with rom_addr=redirect_pc at R+1. The first target instruction is valid at R+3 with a 1-cycle ROM.
- inst_data and inst_pc are stable while inst_valid=1 and inst_ready=0, unless a redirect occurs.

## Structure
- `INST_BYTES (=4, default for PC_STEP) is added to include.v; `BUS_WIDTH and `DATA_WIDTH come from include.v.
- One sub-module, fetch_fifo: a parameterised synchronous FIFO with push, pop, flush, count and registered head.
- The credit check, PC tag queue and drop counter stay in ifu_prefetch.

## Test plan
- Reset release, rom_gnt=1, 1-cycle rvalid, inst_ready=1 → rom_addr 0,4,8,… every cycle; inst_pc 0,4,8 on consecutive cycles starting cycle 3.
- inst_ready=0 for 10 cycles → at most DEPTH=4 grants outstanding+buffered; rom_req drops; head stays inst_pc=0. Releasing ready streams 0,4,8,12,16 with no gaps or duplicates.
- 3-cycle ROM latency with 3 requests in flight, redirect to 0x100 → the 3 stale responses are dropped; the next inst_pc is 0x100, then 0x104.
- Redirect in the same cycle as rom_rvalid and pop → the returning word is discarded, the pop is ignored, and inst_valid=0 the next cycle.
- rom_gnt toggling randomly and fetch_pc near 0xFFFFFFFC → addresses wrap to 0x0 and the PC/data pairing stays correct.
- rst_n asserted with FIFO full → all outputs return to reset values asynchronously; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch_pkg.sv
// rtl/ifu_prefetch_pkg.sv - shared widths and entry type for the prefetching fetch unit
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INST_BYTES
`define INST_BYTES 4
`endif

package ifu_prefetch_pkg;

    localparam int BUS_WIDTH  = `BUS_WIDTH;
    localparam int DATA_WIDTH = `DATA_WIDTH;
    localparam int INST_BYTES = `INST_BYTES;

    typedef logic [BUS_WIDTH-1:0]  pc_t;
    typedef logic [DATA_WIDTH-1:0] inst_t;

    typedef struct packed {
        inst_t data;
        pc_t   pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - ROM request/grant port, redirect and IF/ID stream of the fetch unit
interface ifu_prefetch_if;
    import ifu_prefetch_pkg::*;

    logic  redirect;
    pc_t   redirect_pc;
    logic  rom_req;
    pc_t   rom_addr;
    logic  rom_gnt;
    logic  rom_rvalid;
    inst_t rom_rdata;
    logic  inst_valid;
    logic  inst_ready;
    inst_t inst_data;
    pc_t   inst_pc;

    modport master (
        input  redirect, redirect_pc,
        output rom_req, rom_addr,
        input  rom_gnt, rom_rvalid, rom_rdata,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect, redirect_pc,
        input  rom_req, rom_addr,
        output rom_gnt, rom_rvalid, rom_rdata,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/ifu_prefetch_fetch_fifo.sv
// rtl/ifu_prefetch_fetch_fifo.sv - synchronous FIFO with flush, occupancy count and registered head
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush && (count != FULL_CNT);
    assign do_pop  = pop && !flush && (count != '0);

    // Storage is cleared on reset so an idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - sequential instruction prefetcher with credit-limited ROM fetch and branch flush
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter pc_t RESET_PC = '0,
    parameter int  PC_STEP  = INST_BYTES
) (
    input  logic           clk,
    input  logic           rst_n,
    ifu_prefetch_if.master bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

    pc_t          fetch_pc;
    logic         started;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credits;

    pc_t          tag_q [DEPTH];
    logic [AW-1:0] tag_wr;
    logic [AW-1:0] tag_rd;

    logic         issue;
    logic         resp;
    logic         drop;
    logic         push;
    logic         pop;
    logic         head_valid;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
    assign credits     = {1'b0, fifo_count} + {1'b0, out_cnt};
    assign bus.rom_req  = started && !bus.redirect && (credits < CREDIT_LIMIT);
    assign bus.rom_addr = fetch_pc;

    assign issue = bus.rom_req && bus.rom_gnt;
    assign resp  = bus.rom_rvalid && (out_cnt != '0);
    assign drop  = resp && (drop_cnt != '0);
    assign push  = resp && !drop && !bus.redirect;
    assign pop   = bus.inst_valid && bus.inst_ready && !bus.redirect;

    assign push_entry = {bus.rom_rdata, tag_q[tag_rd]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started  <= 1'b0;
            fetch_pc <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
        end else begin
            started <= 1'b1;
            out_cnt <= out_cnt + CW'(issue) - CW'(resp);
            if (bus.redirect) begin
                // Everything still outstanding belongs to the abandoned path.
                fetch_pc <= bus.redirect_pc;
                drop_cnt <= out_cnt - CW'(resp);
                tag_wr   <= '0;
                tag_rd   <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + pc_t'(PC_STEP);
                    tag_wr   <= tag_wr + 1'b1;
                end
                if (drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (push) begin
                    tag_rd <= tag_rd + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_q[tag_wr] <= fetch_pc;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (bus.redirect),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head_data  (head_entry)
    );

    assign bus.inst_valid = head_valid;
    assign bus.inst_data  = head_entry.data;
    assign bus.inst_pc    = head_entry.pc;

    assert property (@(posedge clk) disable iff (!rst_n) !(bus.rom_rvalid && (out_cnt == '0)));

endmodule
